// File: rtl/wb_stage_pkg.sv
// Shared widths and load opcodes for the MiniMIPS32 write-back stage.
// The aluop codes must stay identical to the ones the ID/EXE/MEM decoders use.
package wb_stage_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;
  localparam int BSEL_BUS       = 4;
  localparam int ALUOP_BUS      = 8;
  localparam int REG_ADDR_BUS   = 5;
  localparam int INST_ADDR_BUS  = 32;

  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_LB  = 8'h90;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_LBU = 8'h91;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_LH  = 8'h92;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_LHU = 8'h93;
  localparam logic [ALUOP_BUS-1:0] MINIMIPS32_LW  = 8'h94;

  typedef enum logic [1:0] {
    LD_NONE,
    LD_BYTE,
    LD_HALF,
    LD_WORD
  } ld_size_e;

endpackage

// File: rtl/wb_stage_hilo_reg.sv
// Architectural HI/LO pair: 64-bit register with write enable.
// Asynchronous active-low reset clears both halves immediately.
module hilo_reg
  import wb_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_we,
  input  logic [DOUBLE_REG_BUS-1:0] i_d,
  output logic [DOUBLE_REG_BUS-1:0] o_q
);

  logic [DOUBLE_REG_BUS-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/wb_stage.sv
// MiniMIPS32 write-back stage: selects ALU or aligned load data for the
// register file, holds HI/LO and drives the debug trace port.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                      cpu_clk_50M,
  input  logic                      cpu_rst_n,
  input  logic [REG_ADDR_BUS-1:0]   wb_wa,
  input  logic                      wb_wreg,
  input  logic [REG_BUS-1:0]        wb_dreg,
  input  logic                      wb_mreg,
  input  logic [BSEL_BUS-1:0]       wb_dre,
  input  logic [ALUOP_BUS-1:0]      wb_aluop,
  input  logic                      wb_whilo,
  input  logic [DOUBLE_REG_BUS-1:0] wb_hilo,
  input  logic [INST_ADDR_BUS-1:0]  wb_pc,
  input  logic [REG_BUS-1:0]        dm,
  output logic [REG_ADDR_BUS-1:0]   wb_wa_o,
  output logic                      wb_wreg_o,
  output logic [REG_BUS-1:0]        wb_wd_o,
  output logic [REG_BUS-1:0]        hi_o,
  output logic [REG_BUS-1:0]        lo_o,
  output logic                      wb_whilo_o,
  output logic [DOUBLE_REG_BUS-1:0] wb_hilo_o,
  output logic [INST_ADDR_BUS-1:0]  debug_wb_pc,
  output logic [3:0]                debug_wb_rf_wen,
  output logic [REG_ADDR_BUS-1:0]   debug_wb_rf_wnum,
  output logic [REG_BUS-1:0]        debug_wb_rf_wdata
);

  // Lane pattern must match the opcode's access size, otherwise the result is 0.
  function automatic logic [REG_BUS-1:0] alignLoad(
    input logic [ALUOP_BUS-1:0] aluop,
    input logic [BSEL_BUS-1:0]  dre,
    input logic [REG_BUS-1:0]   data
  );
    ld_size_e            size;
    logic [7:0]          b;
    logic [15:0]         h;
    logic [REG_BUS-1:0]  r;
    size = LD_NONE;
    b    = '0;
    h    = '0;
    r    = '0;
    case (dre)
      4'b0001: begin size = LD_BYTE; b = data[7:0];   end
      4'b0010: begin size = LD_BYTE; b = data[15:8];  end
      4'b0100: begin size = LD_BYTE; b = data[23:16]; end
      4'b1000: begin size = LD_BYTE; b = data[31:24]; end
      4'b0011: begin size = LD_HALF; h = data[15:0];  end
      4'b1100: begin size = LD_HALF; h = data[31:16]; end
      4'b1111: size = LD_WORD;
      default: size = LD_NONE;
    endcase
    case (aluop)
      MINIMIPS32_LB:  if (size == LD_BYTE) r = {{24{b[7]}}, b};
      MINIMIPS32_LBU: if (size == LD_BYTE) r = {24'b0, b};
      MINIMIPS32_LH:  if (size == LD_HALF) r = {{16{h[15]}}, h};
      MINIMIPS32_LHU: if (size == LD_HALF) r = {16'b0, h};
      MINIMIPS32_LW:  if (size == LD_WORD) r = data;
      default:        r = '0;
    endcase
    return r;
  endfunction

  logic [REG_BUS-1:0]        w_wd;
  logic [DOUBLE_REG_BUS-1:0] w_hilo_q;

  assign w_wd = wb_mreg ? alignLoad(wb_aluop, wb_dre, dm) : wb_dreg;

  hilo_reg u_hilo_reg (
    .clk   (cpu_clk_50M),
    .rst_n (cpu_rst_n),
    .i_we  (wb_whilo),
    .i_d   (wb_hilo),
    .o_q   (w_hilo_q)
  );

  assign wb_wa_o    = wb_wa;
  assign wb_wreg_o  = wb_wreg;
  assign wb_wd_o    = w_wd;

  // No bypass here: EXE forwards the in-flight value from wb_whilo_o/wb_hilo_o.
  assign hi_o       = w_hilo_q[63:32];
  assign lo_o       = w_hilo_q[31:0];
  assign wb_whilo_o = wb_whilo;
  assign wb_hilo_o  = wb_hilo;

  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_wen   = {4{wb_wreg}};
  assign debug_wb_rf_wnum  = wb_wa;
  assign debug_wb_rf_wdata = w_wd;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed steps push expected values into
// a scoreboard queue, which is drained and compared once outputs settle.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clock;
  logic        resetN;
  logic [4:0]  wa;
  logic        wreg;
  logic [31:0] dreg;
  logic        mreg;
  logic [3:0]  dre;
  logic [7:0]  aluop;
  logic        whilo;
  logic [63:0] hilo;
  logic [31:0] pc;
  logic [31:0] dmData;

  logic [4:0]  waOut;
  logic        wregOut;
  logic [31:0] wdOut;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        whiloOut;
  logic [63:0] hiloOut;
  logic [31:0] tracePc;
  logic [3:0]  traceWen;
  logic [4:0]  traceWnum;
  logic [31:0] traceWdata;

  int checks = 0;
  int errors = 0;

  string       tagQ[$];
  int          kindQ[$];
  logic [63:0] expQ[$];

  wb_stage dut (
    .cpu_clk_50M       (clock),
    .cpu_rst_n         (resetN),
    .wb_wa             (wa),
    .wb_wreg           (wreg),
    .wb_dreg           (dreg),
    .wb_mreg           (mreg),
    .wb_dre            (dre),
    .wb_aluop          (aluop),
    .wb_whilo          (whilo),
    .wb_hilo           (hilo),
    .wb_pc             (pc),
    .dm                (dmData),
    .wb_wa_o           (waOut),
    .wb_wreg_o         (wregOut),
    .wb_wd_o           (wdOut),
    .hi_o              (hiOut),
    .lo_o              (loOut),
    .wb_whilo_o        (whiloOut),
    .wb_hilo_o         (hiloOut),
    .debug_wb_pc       (tracePc),
    .debug_wb_rf_wen   (traceWen),
    .debug_wb_rf_wnum  (traceWnum),
    .debug_wb_rf_wdata (traceWdata)
  );

  // Free-running 100 MHz-style clock for the bench.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Kind codes: 0 wd, 1 trace wen, 2 {hi,lo}, 3 whilo_o, 4 hilo_o,
  // 5 address/pc passthrough, 6 trace wdata.
  function automatic logic [63:0] observe(input int kind);
    case (kind)
      0: return {32'b0, wdOut};
      1: return {60'b0, traceWen};
      2: return {hiOut, loOut};
      3: return {63'b0, whiloOut};
      4: return hiloOut;
      5: return {21'b0, waOut, traceWnum, wregOut, tracePc};
      6: return {32'b0, traceWdata};
      default: return 64'h0;
    endcase
  endfunction

  task automatic pushExpect(input string tag, input int kind, input logic [63:0] value);
    tagQ.push_back(tag);
    kindQ.push_back(kind);
    expQ.push_back(value);
  endtask

  // Drives one register-file path transaction and records what WB must produce.
  task automatic applyStimulus(
    input string       tag,
    input logic        iWreg,
    input logic [4:0]  iWa,
    input logic [31:0] iDreg,
    input logic        iMreg,
    input logic [3:0]  iDre,
    input logic [7:0]  iAluop,
    input logic [31:0] iDm,
    input logic [31:0] iPc,
    input logic [31:0] expWd
  );
    wreg   = iWreg;
    wa     = iWa;
    dreg   = iDreg;
    mreg   = iMreg;
    dre    = iDre;
    aluop  = iAluop;
    dmData = iDm;
    pc     = iPc;
    pushExpect({tag, "_wd"}, 0, {32'b0, expWd});
    pushExpect({tag, "_wen"}, 1, {60'b0, {4{iWreg}}});
    pushExpect({tag, "_pass"}, 5, {21'b0, iWa, iWa, iWreg, iPc});
    pushExpect({tag, "_trwd"}, 6, {32'b0, expWd});
  endtask

  // Drains the scoreboard against the settled DUT outputs.
  task automatic checkOutput();
    string       tag;
    int          kind;
    logic [63:0] expected;
    logic [63:0] observed;
    while (expQ.size() > 0) begin
      tag      = tagQ.pop_front();
      kind     = kindQ.pop_front();
      expected = expQ.pop_front();
      observed = observe(kind);
      checks++;
      assert (observed === expected) else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
    end
  endtask

  // Single directed sequence: reset, load/ALU paths, HI/LO writes, async reset.
  initial begin
    resetN = 1'b0;
    wa = '0; wreg = 1'b0; dreg = '0; mreg = 1'b0; dre = '0; aluop = '0;
    whilo = 1'b0; hilo = '0; pc = '0; dmData = '0;

    @(posedge clock); #1;
    pushExpect("reset_hilo", 2, 64'h0);
    pushExpect("reset_whilo", 3, 64'h0);
    checkOutput();
    @(negedge clock);
    resetN = 1'b1;

    applyStimulus("lb_lane2", 1'b1, 5'd3, 32'h0, 1'b1, 4'b0100, MINIMIPS32_LB,
                  32'h12803456, 32'hBFC00010, 32'hFFFFFF80);
    #1 checkOutput();
    applyStimulus("lhu_hi", 1'b1, 5'd4, 32'h0, 1'b1, 4'b1100, MINIMIPS32_LHU,
                  32'h80010000, 32'hBFC00014, 32'h00008001);
    #1 checkOutput();
    applyStimulus("lh_hi", 1'b1, 5'd5, 32'h0, 1'b1, 4'b1100, MINIMIPS32_LH,
                  32'h80010000, 32'hBFC00018, 32'hFFFF8001);
    #1 checkOutput();
    applyStimulus("alu_nowr", 1'b0, 5'd6, 32'hDEADBEEF, 1'b0, 4'b0000, 8'h00,
                  32'h5555AAAA, 32'hBFC0001C, 32'hDEADBEEF);
    #1 checkOutput();
    applyStimulus("bad_lanes", 1'b1, 5'd7, 32'h11111111, 1'b1, 4'b0101, MINIMIPS32_LW,
                  32'hCAFEF00D, 32'hBFC00020, 32'h00000000);
    #1 checkOutput();
    applyStimulus("lw_word", 1'b1, 5'd8, 32'h0, 1'b1, 4'b1111, MINIMIPS32_LW,
                  32'hCAFEF00D, 32'hBFC00024, 32'hCAFEF00D);
    #1 checkOutput();
    applyStimulus("lbu_lane3", 1'b1, 5'd9, 32'h0, 1'b1, 4'b1000, MINIMIPS32_LBU,
                  32'hF0123456, 32'hBFC00028, 32'h000000F0);
    #1 checkOutput();
    applyStimulus("lb_lane0_pos", 1'b1, 5'd10, 32'h0, 1'b1, 4'b0001, MINIMIPS32_LB,
                  32'hFFFFFF7F, 32'hBFC0002C, 32'h0000007F);
    #1 checkOutput();
    applyStimulus("lh_lo", 1'b1, 5'd11, 32'h0, 1'b1, 4'b0011, MINIMIPS32_LH,
                  32'h0000C001, 32'hBFC00030, 32'hFFFFC001);
    #1 checkOutput();
    applyStimulus("notload_mreg", 1'b1, 5'd12, 32'h0, 1'b1, 4'b1111, 8'h21,
                  32'hCAFEF00D, 32'hBFC00034, 32'h00000000);
    #1 checkOutput();
    applyStimulus("lb_on_word", 1'b1, 5'd13, 32'h0, 1'b1, 4'b1111, MINIMIPS32_LB,
                  32'hCAFEF00D, 32'hBFC00038, 32'h00000000);
    #1 checkOutput();

    // MULT result: registered value changes only after the edge.
    @(posedge clock); #1;
    whilo = 1'b1;
    hilo  = 64'h00000001_FFFFFFFE;
    #1;
    pushExpect("mult_same_hilo", 2, 64'h0);
    pushExpect("mult_same_whilo", 3, 64'h1);
    pushExpect("mult_same_fwd", 4, 64'h00000001_FFFFFFFE);
    checkOutput();
    @(posedge clock); #1;
    whilo = 1'b0;
    hilo  = 64'h0;
    #1;
    pushExpect("mult_next_hilo", 2, 64'h00000001_FFFFFFFE);
    pushExpect("mult_next_whilo", 3, 64'h0);
    checkOutput();

    // Back-to-back writes A then B.
    @(negedge clock);
    whilo = 1'b1;
    hilo  = 64'hAAAA0001_AAAA0002;
    @(posedge clock); #1;
    hilo  = 64'hBBBB0003_BBBB0004;
    #1;
    pushExpect("b2b_A", 2, 64'hAAAA0001_AAAA0002);
    checkOutput();
    @(posedge clock); #1;
    whilo = 1'b0;
    hilo  = 64'h0;
    #1;
    pushExpect("b2b_B", 2, 64'hBBBB0003_BBBB0004);
    checkOutput();
    @(posedge clock); #1;
    pushExpect("b2b_hold", 2, 64'hBBBB0003_BBBB0004);
    checkOutput();

    // Reset pulse between edges while a write is pending; release before the edge.
    whilo = 1'b1;
    hilo  = 64'h12345678_9ABCDEF0;
    #1 resetN = 1'b0;
    #1;
    pushExpect("async_reset", 2, 64'h0);
    checkOutput();
    #1 resetN = 1'b1;
    #1;
    pushExpect("reset_released", 2, 64'h0);
    checkOutput();
    @(posedge clock); #1;
    whilo = 1'b0;
    #1;
    pushExpect("write_after_release", 2, 64'h12345678_9ABCDEF0);
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
